load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/load_extract.sv | 45 ++++
 rtl/load_store_unit.sv | 155 +++++++++++++++
 tb/tb_load_store_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared types and constants for the load/store unit.
//   lsu_state_t : FSM state encoding (IDLE / BUSY / DONE)
//   F3_*        : Funct3 encodings for loads and stores
//   store_be    : byte-enable pattern for a store of a given size/offset
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_SB:   be = 4'b0001 << off;
            F3_SH:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_extract.sv
// load_extract -- combinational lane select and sign/zero extension of a
// loaded memory word.
//   word   : raw 32-bit word returned by memory
//   Funct3 : load type (LB/LH/LW/LBU/LHU)
//   addr   : byte offset within the word (addr[1:0] of the access)
//   value  : extended load result
module load_extract
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [2:0]        Funct3,
    input  logic [1:0]        addr,
    output logic [DATA_W-1:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
    end

    assign half_sel = addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        value = word;
        case (Funct3)
            F3_LB:   value = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  value = {{(DATA_W-8){1'b0}}, byte_sel};
            F3_LH:   value = {{(DATA_W-16){half_sel[15]}}, half_sel};
            F3_LHU:  value = {{(DATA_W-16){1'b0}}, half_sel};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit -- issues one memory transaction per load/store
// instruction and stalls the pipeline until memory acknowledges.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for MemRead/MemWrite; a legal access is latched here
// BUSY  | mem_req high, request fields frozen, waiting for mem_ack
// DONE  | one cycle with stall low so the pipeline advances; inputs
//       | ignored so the same instruction is not re-issued
//
// Ports:
//   clk, reset            : clock, async active-high reset
//   MemRead, MemWrite     : access requests (read wins if both high)
//   Funct3, addr, wd      : access size/sign, byte address, store data
//   rd                    : registered, extended load result
//   stall                 : pipeline hold
//   fault                 : combinational misaligned/illegal access flag
//   mem_req .. mem_ack    : word-aligned memory request interface
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    output logic              stall,
    output logic              fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    lsu_state_t        state, state_next;
    logic              access;
    logic              issue;
    logic              ld_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] st_data;
    logic [DATA_W-1:0] ld_value;

    assign access = MemRead | MemWrite;

    // Fault reflects the current inputs only; a read takes priority, so
    // with both requests high the load decoding applies.
    always_comb begin
        fault = 1'b0;
        if (MemRead) begin
            case (Funct3)
                F3_LB, F3_LBU: fault = 1'b0;
                F3_LH, F3_LHU: fault = addr[0];
                F3_LW:         fault = |addr[1:0];
                default:       fault = 1'b1;
            endcase
        end else if (MemWrite) begin
            case (Funct3)
                F3_SB:   fault = 1'b0;
                F3_SH:   fault = addr[0];
                F3_SW:   fault = |addr[1:0];
                default: fault = 1'b1;
            endcase
        end
    end

    assign issue = (state == IDLE) && access && !fault;

    always_comb begin
        st_data = wd;
        case (Funct3)
            F3_SB:   st_data = {4{wd[7:0]}};
            F3_SH:   st_data = {2{wd[15:0]}};
            default: st_data = wd;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue)   state_next = BUSY;
            BUSY:    if (mem_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stall rises combinationally in the issue cycle so the pipeline never
    // advances past an instruction that has just been accepted.
    always_comb begin
        mem_req = 1'b0;
        stall   = 1'b0;
        case (state)
            IDLE:    stall = issue;
            BUSY: begin
                mem_req = 1'b1;
                stall   = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
                stall   = 1'b0;
            end
        endcase
    end

    // Request fields only load on issue, so they stay frozen through BUSY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            ld_q      <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
        end else if (issue) begin
            mem_we    <= !MemRead;
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_be    <= MemRead ? 4'b1111 : store_be(Funct3, addr[1:0]);
            mem_wdata <= MemRead ? '0 : st_data;
            ld_q      <= MemRead;
            f3_q      <= Funct3;
            off_q     <= addr[1:0];
        end
    end

    load_extract #(
        .DATA_W (DATA_W)
    ) u_load_extract (
        .word   (mem_rdata),
        .Funct3 (f3_q),
        .addr   (off_q),
        .value  (ld_value)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  rd <= '0;
        else if ((state == BUSY) && mem_ack && ld_q) rd <= ld_value;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit -- directed-vector bench for load_store_unit.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] addr, wd, rd;
    logic        stall, fault;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .addr      (addr),
        .wd        (wd),
        .rd        (rd),
        .stall     (stall),
        .fault     (fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one legal access and walks it through BUSY, acking after
    // 'delay' extra cycles. Request fields are checked every BUSY cycle;
    // n_stall counts the BUSY cycles with stall high.
    task automatic access(input string tag, input logic r, input logic w,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wdat, input logic [31:0] rdata,
                          input int delay, input logic exp_we,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input int exp_nstall);
        int  n_stall;
        bit  ended;
        n_stall = 0;
        ended   = 0;
        @(negedge clk);
        MemRead = r; MemWrite = w; Funct3 = f3; addr = a; wd = wdat; mem_rdata = rdata;
        #1;
        chk({tag, " issue_stall"}, {31'b0, stall}, 32'd1);
        chk({tag, " issue_fault"}, {31'b0, fault}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) begin
                ended = 1;
                break;
            end
            n_stall++;
            chk({tag, " req"},   {31'b0, mem_req}, 32'd1);
            chk({tag, " we"},    {31'b0, mem_we},  {31'b0, exp_we});
            chk({tag, " addr"},  mem_addr,         exp_addr);
            chk({tag, " be"},    {28'b0, mem_be},  {28'b0, exp_be});
            chk({tag, " wdata"}, mem_wdata,        exp_wdata);
            mem_ack = (i == delay);
        end
        mem_ack = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        chk({tag, " completed"}, {31'b0, ended}, 32'd1);
        chk({tag, " busy_stall_cycles"}, n_stall, exp_nstall);
    endtask

    task automatic faulty(input string tag, input logic r, input logic w,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp_rd);
        @(negedge clk);
        MemRead = r; MemWrite = w; Funct3 = f3; addr = a; wd = 32'hDEAD_BEEF;
        #1;
        chk({tag, " fault"}, {31'b0, fault}, 32'd1);
        chk({tag, " stall"}, {31'b0, stall}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk({tag, " no_req"},   {31'b0, mem_req}, 32'd0);
            chk({tag, " no_stall"}, {31'b0, stall},   32'd0);
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        chk({tag, " rd_kept"}, rd, exp_rd);
    endtask

    initial begin
        reset = 1'b1; MemRead = 0; MemWrite = 0; Funct3 = 0; addr = 0; wd = 0;
        mem_rdata = 0; mem_ack = 0;
        repeat (2) @(negedge clk);
        chk("rst rd",    rd,                 32'h0);
        chk("rst req",   {31'b0, mem_req},   32'd0);
        chk("rst we",    {31'b0, mem_we},    32'd0);
        chk("rst be",    {28'b0, mem_be},    32'd0);
        chk("rst addr",  mem_addr,           32'h0);
        chk("rst wdata", mem_wdata,          32'h0);
        chk("rst stall", {31'b0, stall},     32'd0);
        reset = 1'b0;

        access("lb", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0,
               0, 32'h100, 4'b1111, 32'h0, 1);
        chk("lb rd", rd, 32'hFFFF_FF80);

        access("sh", 0, 1, 3'b001, 32'h0E, 32'h0000_ABCD, 32'h1357_9BDF, 0,
               1, 32'h0C, 4'b1100, 32'hABCD_ABCD, 1);
        chk("sh rd_kept", rd, 32'hFFFF_FF80);

        access("lh", 1, 0, 3'b001, 32'h02, 32'h0, 32'h8001_7FFF, 0,
               0, 32'h00, 4'b1111, 32'h0, 1);
        chk("lh rd", rd, 32'hFFFF_8001);

        access("lbu", 1, 0, 3'b100, 32'h01, 32'h0, 32'h0000_9A00, 1,
               0, 32'h00, 4'b1111, 32'h0, 2);
        chk("lbu rd", rd, 32'h0000_009A);

        access("sb", 0, 1, 3'b000, 32'h2002, 32'h0000_00A5, 32'h0, 0,
               1, 32'h2000, 4'b0100, 32'hA5A5_A5A5, 1);
        chk("sb rd_kept", rd, 32'h0000_009A);

        access("lhu", 1, 0, 3'b101, 32'h22, 32'h0, 32'hBEEF_0000, 3,
               0, 32'h20, 4'b1111, 32'h0, 4);
        chk("lhu rd", rd, 32'h0000_BEEF);

        // ack while idle must not disturb anything
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        repeat (2) begin
            @(negedge clk);
            chk("idle_ack req", {31'b0, mem_req}, 32'd0);
            chk("idle_ack rd",  rd,               32'h0000_BEEF);
        end
        mem_ack = 1'b0;

        faulty("lw_mis",   1, 0, 3'b010, 32'h05, 32'h0000_BEEF);
        faulty("ld_f3110", 1, 0, 3'b110, 32'h00, 32'h0000_BEEF);
        faulty("st_f3011", 0, 1, 3'b011, 32'h00, 32'h0000_BEEF);
        faulty("sh_mis",   0, 1, 3'b001, 32'h01, 32'h0000_BEEF);

        access("rw_lw", 1, 1, 3'b010, 32'h40, 32'h7777_7777, 32'hCAFE_F00D, 0,
               0, 32'h40, 4'b1111, 32'h0, 1);
        chk("rw_lw rd", rd, 32'hCAFE_F00D);

        // reset in the middle of a store, then a stray ack afterwards
        @(negedge clk);
        MemWrite = 1'b1; Funct3 = 3'b010; addr = 32'h10; wd = 32'h1234_5678;
        @(negedge clk);
        chk("rstbusy req_before", {31'b0, mem_req}, 32'd1);
        chk("rstbusy we_before",  {31'b0, mem_we},  32'd1);
        #2;
        reset = 1'b1; MemWrite = 1'b0;
        #1;
        chk("rstbusy req_async",  {31'b0, mem_req}, 32'd0);
        chk("rstbusy we_async",   {31'b0, mem_we},  32'd0);
        chk("rstbusy be_async",   {28'b0, mem_be},  32'd0);
        chk("rstbusy rd_async",   rd,               32'h0);
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        repeat (2) begin
            @(negedge clk);
            chk("rstbusy late_req",   {31'b0, mem_req}, 32'd0);
            chk("rstbusy late_stall", {31'b0, stall},   32'd0);
            chk("rstbusy late_rd",    rd,               32'h0);
        end
        mem_ack = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
